scan_sequencer: RTL and testbench

Frame sequencer for the golden-pattern scan chain in the user module. It replaces hand-driven `load_gold`/`scan_en` stimulus with a state machine. Each frame it pulses a golden-value load, then enables exactly `CHAIN_LEN` shift cycles. It compares each bit leaving the chain against a golden word and reports per-frame pass/fail plus saturating error and wrapping frame counters. It sits between the top-level control pins and the scan-chain datapath.

---
 rtl/scan_sequencer.sv | 115 +++++++++++
 tb/tb_scan_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Frame sequencer for the golden-pattern scan chain: load pulse, CHAIN_LEN shifts,
// bitwise compare against GOLDEN, per-frame result plus error/frame counters.
module scan_sequencer #(
  parameter int                   CHAIN_LEN  = 16,
  parameter logic [CHAIN_LEN-1:0] GOLDEN     = 16'hA5C3,
  parameter int                   GAP_CYCLES = 4,
  parameter int                   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             scan_data,
  output logic             load_gold,
  output logic             scan_en,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] frame_count,
  output logic [1:0]       state_dbg
);

  localparam int IDX_W = $clog2(CHAIN_LEN);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAIN_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic              frame_err;
  logic              start_accept;
  logic              bit_err;
  logic              frame_end;

  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    bit_err      = 1'b0;
    frame_end    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next   = S_LOAD;
          start_accept = 1'b1;
        end
      end
      S_LOAD: state_next = S_SHIFT;
      S_SHIFT: begin
        bit_err = (scan_data != GOLDEN[idx]);
        if (idx == IDX_LAST) begin
          state_next = S_GAP;
          frame_end  = !abort;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = continuous ? S_LOAD : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort wins over everything, but the compare of this cycle still counts.
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      frame_err   <= 1'b0;
      frame_done  <= 1'b0;
      mismatch    <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      state      <= state_next;
      frame_done <= frame_end;

      if (state == S_LOAD)       idx <= '0;
      else if (state == S_SHIFT) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (state == S_LOAD) frame_err <= 1'b0;
      else if (bit_err)    frame_err <= 1'b1;

      if (start_accept)                        err_count <= '0;
      else if (bit_err && err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);

      if (start_accept)   frame_count <= '0;
      else if (frame_end) frame_count <= frame_count + CNT_W'(1);

      if (start_accept)   mismatch <= 1'b0;
      else if (frame_end) mismatch <= frame_err | bit_err;
    end
  end

  assign load_gold = (state == S_LOAD);
  assign scan_en   = (state == S_SHIFT);
  assign shift_en  = (state == S_SHIFT);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: frame-position reference model with per-cycle compare,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_scan_sequencer;
  localparam int L = 8;
  localparam int G = 2;
  localparam int W = 4;
  localparam logic [L-1:0] GOLD = 8'hA5;

  logic clk = 1'b0;
  logic rstn = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0, scan_data = 1'b0;
  logic load_gold, scan_en, shift_en, busy, frame_done, mismatch;
  logic [W-1:0] err_count, frame_count;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  scan_sequencer #(.CHAIN_LEN(L), .GOLDEN(GOLD), .GAP_CYCLES(G), .CNT_W(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .continuous(continuous), .abort(abort),
    .scan_data(scan_data), .load_gold(load_gold), .scan_en(scan_en), .shift_en(shift_en),
    .busy(busy), .frame_done(frame_done), .mismatch(mismatch), .err_count(err_count),
    .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: position within the frame (0 = load, 1..L = shift, L+1..L+G = gap)
  bit m_active = 1'b0;
  int m_pos = 0, m_tot = 0, m_frames = 0;
  bit m_mism = 1'b0, m_ferr = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rstn) begin
      m_active = 1'b0; m_tot = 0; m_frames = 0; m_mism = 1'b0;
    end else if (m_active) begin
      if (m_pos == 0) m_ferr = 1'b0;
      if (m_pos >= 1 && m_pos <= L && scan_data != GOLD[m_pos-1]) begin
        m_tot++; m_ferr = 1'b1;
      end
      if (abort) m_active = 1'b0;
      else if (m_pos == L) begin
        m_frames++; m_mism = m_ferr; exp_q.push_back(W'(m_frames)); m_pos++;
      end else if (m_pos == L + G) begin
        if (continuous) m_pos = 0; else m_active = 1'b0;
      end else m_pos++;
    end else if (start && !abort) begin
      m_active = 1'b1; m_pos = 0; m_tot = 0; m_frames = 0; m_mism = 1'b0;
    end
  end

  // scoreboard compare on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("load_gold", load_gold, m_active && m_pos == 0);
      check("scan_en", scan_en, m_active && m_pos >= 1 && m_pos <= L);
      check("shift_en", shift_en, m_active && m_pos >= 1 && m_pos <= L);
      check("busy", busy, m_active);
      check("state_idle", state_dbg == 2'd0, !m_active);
      check("frame_done", frame_done, m_active && m_pos == L + 1);
      check("mismatch", mismatch, m_mism);
      check("err_count", err_count, (m_tot > 15) ? 15 : m_tot);
      check("frame_count", frame_count, m_frames % 16);
      if (frame_done) begin
        if (exp_q.size() == 0) check("frame_q_empty", 1, 0);
        else check("frame_q", frame_count, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [L-1:0] pat, input bit hold_start);
    start = 1'b1;
    tick();
    start = hold_start;
    tick();
    for (int i = 0; i < L; i++) begin
      scan_data = pat[i];
      tick();
    end
    check("frame_done_at_T+10", frame_done, 1);
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic wait_done(output int t);
    for (int i = 0; i < 30 && !frame_done; i++) tick();
    check("frame_done_wait", frame_done, 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) tick();
    check("idle_wait", busy, 0);
  endtask

  initial begin
    int t, prev;
    rstn = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    check("rst_frames", frame_count, 0);
    rstn = 1'b1;
    tick();

    // clean frame
    run_frame(GOLD, 1'b0);
    check("clean_err", err_count, 0);
    check("clean_mism", mismatch, 0);
    check("clean_frames", frame_count, 1);
    check("clean_busy_T+12", busy, 0);

    // two bad bits (0 and 7)
    run_frame(GOLD ^ 8'h81, 1'b0);
    check("bad_err", err_count, 2);
    check("bad_mism", mismatch, 1);
    check("bad_frames", frame_count, 1);

    // start held during shift and gap
    run_frame(GOLD, 1'b1);
    check("ign_frames", frame_count, 1);
    check("ign_busy", busy, 0);
    tick(3);
    check("ign_still_idle", busy, 0);
    check("ign_frames2", frame_count, 1);

    // continuous with saturation and wrap
    continuous = 1'b1;
    scan_data = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    prev = -1;
    for (int k = 1; k <= 16; k++) begin
      wait_done(t);
      check("cont_err", err_count, (4 * k > 15) ? 15 : 4 * k);
      check("cont_frames", frame_count, k % 16);
      if (prev >= 0) check("cont_period", t - prev, 11);
      prev = t;
      if (k == 16) continuous = 1'b0;
      tick();
    end
    wait_idle();
    check("wrap_frames", frame_count, 0);

    // abort at shift index 3
    scan_data = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    check("abort_err", err_count, 2);
    check("abort_frames", frame_count, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    tick();
    check("start_abort_load", load_gold, 0);
    check("start_abort_busy2", busy, 0);

    // reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    rstn = 1'b0;
    tick();
    check("rstmid_busy", busy, 0);
    check("rstmid_shift", shift_en, 0);
    check("rstmid_done", frame_done, 0);
    check("rstmid_state", state_dbg, 0);
    check("rstmid_err", err_count, 0);
    rstn = 1'b1;
    tick();
    run_frame(GOLD, 1'b0);
    check("post_rst_frames", frame_count, 1);
    check("post_rst_err", err_count, 0);

    // randomized traffic
    repeat (3000) begin
      start      = ($urandom_range(0, 9) == 0);
      continuous = ($urandom_range(0, 2) != 0);
      abort      = ($urandom_range(0, 59) == 0);
      scan_data  = $urandom_range(0, 1);
      rstn       = ($urandom_range(0, 299) != 0);
      tick();
    end
    rstn = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b0;
    tick(L + G + 5);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
